router_pkt_serializer: RTL and testbench

Upstream driver for one router input port. Collects a whole packet as a byte stream with a 4-bit destination address, buffers it, then serialises it gaplessly onto the router's per-port serial protocol (`din`, `frame_n`, `valid_n`). The bench or traffic source instantiates one per router input port, 16 in total, and each instance drives that port's bit of the router input buses.

---
 rtl/router_pkt_serializer.sv | 208 ++++++++++++++++++++
 tb/tb_router_pkt_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_serializer.sv
// router_pkt_serializer
// Buffers one packet (up to MAX_BYTES) from a byte stream, then sends it on a
// router input port as: 4-bit address (LSB first), PAD_CYCLES pad bits of 1,
// then the payload bytes LSB first with valid_n low. frame_n rises on the
// final payload bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the first byte of a packet
// LOAD   | collecting further bytes until s_last or the buffer is full
// ADDR   | 4 cycles of destination address bits
// PAD    | PAD_CYCLES cycles of pad bits between address and payload
// DATA   | 8 x count payload bits
// GAP    | one quiet cycle before the next packet can be accepted
//
// Serial outputs are registered from the current state, so each one appears
// on the line one cycle after the FSM enters the state that produces it.
module router_pkt_serializer #(
  parameter int MAX_BYTES  = 16,
  parameter int PAD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic [3:0] s_da,
  output logic       din,
  output logic       frame_n,
  output logic       valid_n,
  output logic       busy,
  output logic       pkt_done,
  output logic       pkt_trunc
);

  localparam int AW     = $clog2(MAX_BYTES);
  localparam int CW     = AW + 1;
  localparam int PH_MAX = (PAD_CYCLES > 4) ? PAD_CYCLES : 4;
  localparam int PW     = $clog2(PH_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDR,
    S_PAD,
    S_DATA,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_buf [MAX_BYTES];
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_bptr;
  logic [2:0]    r_bit;
  logic [PW-1:0] r_phase;
  logic [3:0]    r_da;
  logic          r_rdy_en;

  logic r_din;
  logic r_frame_n;
  logic r_valid_n;
  logic r_pkt_done;
  logic r_pkt_trunc;

  logic          w_xfer;
  logic [CW-1:0] w_cnt_inc;
  logic          w_full;
  logic          w_close;
  logic          w_phase_tc;
  logic          w_last_bit;
  logic [AW-1:0] w_wr_idx;
  logic [7:0]    w_rd_byte;
  logic [1:0]    w_addr_idx;
  logic          w_din_nxt;
  logic          w_frame_nxt;
  logic          w_valid_nxt;
  logic          w_done_nxt;

  // r_rdy_en keeps s_ready low for the first cycle after reset is released.
  assign s_ready    = ((r_state == S_IDLE) || (r_state == S_LOAD)) && r_rdy_en && !reset;
  assign busy       = (r_state != S_IDLE) && !reset;
  assign w_xfer     = s_valid && s_ready;
  assign w_cnt_inc  = (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_full     = (w_cnt_inc == CW'(MAX_BYTES));
  assign w_close    = w_xfer && (s_last || w_full);
  assign w_phase_tc = (r_phase == '0);
  assign w_last_bit = (r_bit == 3'd7) && ({1'b0, r_bptr} == (r_cnt - CW'(1)));
  assign w_wr_idx   = (r_state == S_IDLE) ? '0 : r_cnt[AW-1:0];
  assign w_rd_byte  = r_buf[r_bptr];
  // phase counts 3..0 in ADDR, so the address bit index is its complement
  assign w_addr_idx = ~r_phase[1:0];

  assign din       = r_din;
  assign frame_n   = r_frame_n;
  assign valid_n   = r_valid_n;
  assign pkt_done  = r_pkt_done;
  assign pkt_trunc = r_pkt_trunc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and next serial output values
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = 1'b0;
    w_frame_nxt = 1'b1;
    w_valid_nxt = 1'b1;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_state_nxt = w_close ? S_ADDR : S_LOAD;
      end
      S_LOAD: begin
        if (w_close) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_frame_nxt = 1'b0;
        w_din_nxt   = r_da[w_addr_idx];
        if (w_phase_tc) w_state_nxt = (PAD_CYCLES > 0) ? S_PAD : S_DATA;
      end
      S_PAD: begin
        w_frame_nxt = 1'b0;
        w_din_nxt   = 1'b1;
        if (w_phase_tc) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_valid_nxt = 1'b0;
        w_din_nxt   = w_rd_byte[r_bit];
        w_frame_nxt = w_last_bit;
        w_done_nxt  = w_last_bit;
        if (w_last_bit) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered serial outputs and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_din       <= 1'b0;
      r_frame_n   <= 1'b1;
      r_valid_n   <= 1'b1;
      r_pkt_done  <= 1'b0;
      r_pkt_trunc <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_din       <= w_din_nxt;
      r_frame_n   <= w_frame_nxt;
      r_valid_n   <= w_valid_nxt;
      r_pkt_done  <= w_done_nxt;
      r_pkt_trunc <= w_xfer && w_full && !s_last;
      r_rdy_en    <= 1'b1;
    end
  end

  // Byte count, address latch, phase down-counter and read pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bptr  <= '0;
      r_bit   <= '0;
      r_phase <= '0;
      r_da    <= '0;
    end else begin
      if (w_xfer) begin
        r_cnt <= w_cnt_inc;
        if (r_state == S_IDLE) r_da <= s_da;
      end
      if (w_close) r_phase <= PW'(3);
      case (r_state)
        S_ADDR: begin
          r_bptr <= '0;
          r_bit  <= '0;
          if (w_phase_tc) r_phase <= PW'(PAD_CYCLES - 1);
          else            r_phase <= r_phase - PW'(1);
        end
        S_PAD: begin
          if (!w_phase_tc) r_phase <= r_phase - PW'(1);
        end
        S_DATA: begin
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_bptr <= r_bptr + AW'(1);
        end
        S_GAP: begin
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Packet buffer write; contents need no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (w_xfer) r_buf[w_wr_idx] <= s_data;
  end

endmodule

// File: tb/tb_router_pkt_serializer.sv
// Directed bench for router_pkt_serializer with default parameters
// (MAX_BYTES=16, PAD_CYCLES=5). Captured payload bits are packed so that
// cap_vec[i] is the i-th payload bit in time; with LSB-first bytes this makes
// cap_vec[8k+7:8k] equal to payload byte k. cap_hdr holds the address and pad
// bits the same way: [3:0] = da, [8:4] = five pad ones.
module tb_router_pkt_serializer;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [3:0] s_da;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       busy;
  logic       pkt_done;
  logic       pkt_trunc;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] cap_vec;
  logic [31:0]  cap_hdr;
  int cap_nbits, cap_nhdr, cap_flow, cap_vlow, cap_done, cap_done_last;
  int cap_rdy, cap_trunc, cap_lat;
  logic cap_to, cap_tail_idle;

  router_pkt_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_da     (s_da),
    .din      (din),
    .frame_n  (frame_n),
    .valid_n  (valid_n),
    .busy     (busy),
    .pkt_done (pkt_done),
    .pkt_trunc(pkt_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one byte, wait (bounded) for acceptance; returns at the negedge
  // right after the accepting edge with s_valid still high.
  task automatic put_byte(input logic [7:0] d, input logic l, input logic [3:0] da);
    int w;
    s_valid = 1'b1; s_data = d; s_last = l; s_da = da; w = 0;
    while (s_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL put_byte_timeout byte %h: s_ready got %b required 1", d, s_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Record one frame from the first frame_n-low cycle to the first idle cycle.
  task automatic capture_frame();
    int n;
    cap_vec = '0; cap_hdr = '0; cap_nbits = 0; cap_nhdr = 0; cap_flow = 0;
    cap_vlow = 0; cap_done = 0; cap_done_last = 0; cap_rdy = 0; cap_trunc = 0;
    cap_lat = 0; cap_to = 1'b0; cap_tail_idle = 1'b0;
    do begin @(negedge clk); cap_lat++; end while (frame_n !== 1'b0 && cap_lat < 60);
    if (frame_n !== 1'b0) begin cap_to = 1'b1; return; end
    n = 0;
    while (!(frame_n === 1'b1 && valid_n === 1'b1) && n < 400) begin
      if (frame_n === 1'b0) cap_flow++;
      if (valid_n === 1'b0) begin
        if (cap_nbits < 128) cap_vec[cap_nbits] = din;
        cap_nbits++; cap_vlow++;
      end else begin
        if (cap_nhdr < 32) cap_hdr[cap_nhdr] = din;
        cap_nhdr++;
      end
      if (pkt_done === 1'b1) begin
        cap_done++;
        if (frame_n === 1'b1 && valid_n === 1'b0) cap_done_last++;
      end
      if (s_ready === 1'b1) cap_rdy++;
      if (pkt_trunc === 1'b1) cap_trunc++;
      n++;
      @(negedge clk);
    end
    if (n >= 400) cap_to = 1'b1;
    cap_tail_idle = (din === 1'b0 && frame_n === 1'b1 && valid_n === 1'b1 && pkt_done === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_da = '0;
    repeat (3) @(negedge clk);
    vectors++; if (s_ready !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_hs: s_ready/busy got %b%b required 00", s_ready, busy); end
    vectors++; if ({din, frame_n, valid_n, pkt_done, pkt_trunc} !== 5'b01100) begin miscompares++;
      $display("FAIL reset_outs: din,frame_n,valid_n,done,trunc got %b required 01100",
               {din, frame_n, valid_n, pkt_done, pkt_trunc}); end
    reset = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_release_cycle: s_ready/busy got %b%b required 00", s_ready, busy); end
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_ready: s_ready got %b required 1", s_ready); end
  endtask

  task automatic test_one_byte();
    put_byte(8'hA5, 1'b1, 4'h3);
    s_valid = 1'b0;
    vectors++; if (s_ready !== 1'b0 || busy !== 1'b1) begin miscompares++;
      $display("FAIL one_direct_addr: s_ready/busy got %b%b required 01", s_ready, busy); end
    capture_frame();
    vectors++; if (cap_to !== 1'b0) begin miscompares++;
      $display("FAIL one_timeout: got %b required 0", cap_to); end
    vectors++; if (cap_lat !== 1) begin miscompares++;
      $display("FAIL one_latency: got %0d required 1", cap_lat); end
    vectors++; if (cap_nhdr !== 9 || cap_hdr[8:0] !== 9'h1F3) begin miscompares++;
      $display("FAIL one_header: got %0d bits %h required 9 bits 1f3", cap_nhdr, cap_hdr[8:0]); end
    vectors++; if (cap_vlow !== 8 || cap_vec[7:0] !== 8'hA5) begin miscompares++;
      $display("FAIL one_payload: got %0d bits %h required 8 bits a5", cap_vlow, cap_vec[7:0]); end
    vectors++; if (cap_flow !== 16) begin miscompares++;
      $display("FAIL one_frame_len: got %0d required 16", cap_flow); end
    vectors++; if (cap_done !== 1 || cap_done_last !== 1) begin miscompares++;
      $display("FAIL one_done: got %0d/%0d required 1/1", cap_done, cap_done_last); end
    vectors++; if (cap_tail_idle !== 1'b1) begin miscompares++;
      $display("FAIL one_tail_idle: got %b required 1", cap_tail_idle); end
  endtask

  task automatic test_multi_byte();
    put_byte(8'h01, 1'b0, 4'hF);
    put_byte(8'h80, 1'b0, 4'h0);
    put_byte(8'hFF, 1'b1, 4'h0);
    s_valid = 1'b0;
    capture_frame();
    vectors++; if (cap_to !== 1'b0) begin miscompares++;
      $display("FAIL multi_timeout: got %b required 0", cap_to); end
    vectors++; if (cap_nhdr !== 9 || cap_hdr[8:0] !== 9'h1FF) begin miscompares++;
      $display("FAIL multi_header: got %0d bits %h required 9 bits 1ff", cap_nhdr, cap_hdr[8:0]); end
    vectors++; if (cap_vlow !== 24 || cap_vec[23:0] !== 24'hFF8001) begin miscompares++;
      $display("FAIL multi_payload: got %0d bits %h required 24 bits ff8001", cap_vlow, cap_vec[23:0]); end
    vectors++; if (cap_flow !== 32 || cap_done_last !== 1) begin miscompares++;
      $display("FAIL multi_frame: len %0d done_last %0d required 32/1", cap_flow, cap_done_last); end
  endtask

  task automatic test_truncate();
    for (int i = 0; i < 16; i++) begin
      put_byte(8'h10 + 8'(i), 1'b0, (i == 0) ? 4'h6 : 4'h9);
      if (i == 14) begin
        vectors++; if (pkt_trunc !== 1'b0) begin miscompares++;
          $display("FAIL trunc_early: got %b required 0", pkt_trunc); end
      end
    end
    s_valid = 1'b0;
    vectors++; if (pkt_trunc !== 1'b1) begin miscompares++;
      $display("FAIL trunc_pulse: got %b required 1", pkt_trunc); end
    capture_frame();
    vectors++; if (cap_to !== 1'b0 || cap_trunc !== 0) begin miscompares++;
      $display("FAIL trunc_frame_flags: timeout %b trunc_cycles %0d required 0/0", cap_to, cap_trunc); end
    vectors++; if (cap_hdr[8:0] !== 9'h1F6) begin miscompares++;
      $display("FAIL trunc_header: got %h required 1f6", cap_hdr[8:0]); end
    vectors++; if (cap_vlow !== 128 || cap_vec !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      miscompares++;
      $display("FAIL trunc_payload: got %0d bits %h", cap_vlow, cap_vec); end
    vectors++; if (cap_flow !== 136) begin miscompares++;
      $display("FAIL trunc_frame_len: got %0d required 136", cap_flow); end
    put_byte(8'h20, 1'b1, 4'h9);
    s_valid = 1'b0;
    capture_frame();
    vectors++; if (cap_hdr[8:0] !== 9'h1F9 || cap_vlow !== 8 || cap_vec[7:0] !== 8'h20) begin
      miscompares++;
      $display("FAIL trunc_next_pkt: hdr %h bits %0d data %h required 1f9/8/20",
               cap_hdr[8:0], cap_vlow, cap_vec[7:0]); end
  endtask

  task automatic test_full_with_last();
    for (int i = 0; i < 16; i++) put_byte(8'(i), (i == 15), 4'h2);
    s_valid = 1'b0;
    vectors++; if (pkt_trunc !== 1'b0) begin miscompares++;
      $display("FAIL full_last_trunc: got %b required 0", pkt_trunc); end
    capture_frame();
    vectors++; if (cap_hdr[8:0] !== 9'h1F2 || cap_vlow !== 128 ||
                   cap_vec !== 128'h0F0E0D0C0B0A09080706050403020100) begin miscompares++;
      $display("FAIL full_last_frame: hdr %h bits %0d data %h", cap_hdr[8:0], cap_vlow, cap_vec); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  hdr_a;
    logic [15:0] pay_a;
    int rdy_a, lat_b;
    fork
      begin
        put_byte(8'h3C, 1'b0, 4'h5);
        put_byte(8'hC3, 1'b1, 4'h5);
        put_byte(8'h5A, 1'b1, 4'hA);
        s_valid = 1'b0;
      end
      begin
        capture_frame();
        hdr_a = cap_hdr[8:0]; pay_a = cap_vec[15:0]; rdy_a = cap_rdy;
        capture_frame();
        lat_b = cap_lat;
      end
    join
    vectors++; if (hdr_a !== 9'h1F5 || pay_a !== 16'hC33C) begin miscompares++;
      $display("FAIL b2b_first: hdr %h data %h required 1f5/c33c", hdr_a, pay_a); end
    vectors++; if (rdy_a !== 0 || cap_rdy !== 0) begin miscompares++;
      $display("FAIL b2b_backpressure: ready cycles %0d/%0d required 0/0", rdy_a, cap_rdy); end
    vectors++; if (lat_b !== 2) begin miscompares++;
      $display("FAIL b2b_gap: idle cycles got %0d required 2", lat_b); end
    vectors++; if (cap_hdr[8:0] !== 9'h1FA || cap_vlow !== 8 || cap_vec[7:0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL b2b_second: hdr %h bits %0d data %h required 1fa/8/5a",
               cap_hdr[8:0], cap_vlow, cap_vec[7:0]); end
  endtask

  task automatic test_reset_mid();
    int w, dones;
    put_byte(8'hFF, 1'b1, 4'h0);
    s_valid = 1'b0;
    w = 0;
    while (valid_n !== 1'b0 && w < 60) begin @(negedge clk); w++; end
    vectors++; if (valid_n !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_wait: valid_n got %b required 0", valid_n); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if ({din, frame_n, valid_n, pkt_done, busy} !== 5'b01100) begin miscompares++;
      $display("FAIL rstmid_idle: din,frame_n,valid_n,done,busy got %b required 01100",
               {din, frame_n, valid_n, pkt_done, busy}); end
    reset = 1'b0;
    dones = 0;
    repeat (12) begin @(negedge clk); if (pkt_done === 1'b1 || frame_n !== 1'b1) dones++; end
    vectors++; if (dones !== 0) begin miscompares++;
      $display("FAIL rstmid_quiet: active cycles got %0d required 0", dones); end
    put_byte(8'h96, 1'b1, 4'hC);
    s_valid = 1'b0;
    capture_frame();
    vectors++; if (cap_hdr[8:0] !== 9'h1FC || cap_vlow !== 8 || cap_vec[7:0] !== 8'h96 ||
                   cap_done_last !== 1) begin miscompares++;
      $display("FAIL rstmid_fresh: hdr %h bits %0d data %h done %0d required 1fc/8/96/1",
               cap_hdr[8:0], cap_vlow, cap_vec[7:0], cap_done_last); end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_da = '0;
    test_reset();
    test_one_byte();
    test_multi_byte();
    test_truncate();
    test_full_with_last();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
